nibble_add_sequencer: RTL
=========================

Name: nibble_add_sequencer

Overview:
- Initiator side of the 4-bit adder-slice en/ready handshake.
- Accepts a W-bit add or subtract request and issues it to one external 4-bit carry-lookahead slice, one nibble at a time, LSB first, rippling the carry between nibbles.
- Collects the sum nibbles and flags, then pulses done.
- Sits between the 8-bit ALU control and the shared slice, so one slice serves full-width arithmetic.

Parameters:
- NIBBLES, 2, number of 4-bit nibbles; data width W = 4*NIBBLES.
- TIMEOUT, 15, max cycles to wait for slice ready per nibble before aborting with err.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- sub  in  1  1 = A - B (B inverted, carry-in forced 1); 0 = A + B + c_in.
- c_in  in  1  carry-in for add; ignored when sub=1.
- a  in  W  operand A; captured on accepted start.
- b  in  W  operand B; captured on accepted start.
- add_en  out  1  enable to slice; held high until slice ready.
- add_a  out  4  current nibble of A to slice.
- add_b  out  4  current nibble of B (inverted if sub) to slice.
- add_c_in  out  1  carry into current nibble.
- add_sum  in  4  slice sum; valid when add_ready=1.
- add_c_out  in  1  slice carry-out; valid when add_ready=1.
- add_ready  in  1  slice completion; meaningful only while add_en=1.
- busy  out  1  high from accepted start until done/err cycle inclusive.
- result  out  W  registered sum; holds until next accepted start.
- c_out  out  1  final carry-out (for sub: 1 = no borrow).
- ovf  out  1  signed overflow: operand sign bits equal (after B inversion), result sign differs.
- zero  out  1  result == 0.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (async, rst_n=0): state IDLE; add_en, busy, done, err, c_out, ovf, add_c_in = 0; result = 0; zero = 1; nibble index = 0; add_a, add_b = 0.
- IDLE: start=1 captures a and b^{W{sub}} into internal registers and carry = sub ? 1 : c_in; clears result. Index=0, go to ISSUE. busy rises the following cycle.
- ISSUE: add_en=1. add_a/add_b present nibble[index] and add_c_in = carry; these are stable for the whole time add_en is high. Wait counter is cleared, then go to WAIT.
- WAIT: add_en stays 1. Each cycle with add_ready=0 increments the wait counter.
  - add_ready=1: latch add_sum into result nibble[index] and carry=add_c_out, then go to GAP.
  - Counter reaches TIMEOUT with no ready: add_en=0, pulse err, result keeps the nibbles completed so far, go to IDLE.
- GAP: add_en=0 for exactly one cycle so the slice clears its internal count.
  - index < NIBBLES-1: index+1, go to ISSUE.
  - Otherwise: go to DONE.
- DONE: c_out=carry, ovf and zero registered from the final result; done=1 for one cycle; go to IDLE.
- Latency: with a slice ready latency L cycles after en rises, total = 1 + NIBBLES*(L+2) + 1 cycles from start to done.
- start outside IDLE is ignored; no queueing.
- add_ready while add_en=0 is ignored.
- Arithmetic is modulo 2^W. A final carry-out does not set err.
- Reset mid-operation aborts immediately: add_en drops asynchronously and no done or err pulse is produced.
- sub with b=0: result=a, c_out=1.

Decomposition:
- Package nibble_seq_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, GAP, DONE};
  - NIBBLE_W=4;
  - a function computing the ovf expression.
- No sub-module. A test-only behavioural slice model, adder_slice_model, with a configurable ready latency is used by the bench.

Test Plan:
- NIBBLES=2, L=3: a=8'h3C, b=8'h47, sub=0, c_in=0 -> result=8'h83, c_out=0, ovf=1, zero=0, done once, add_en low exactly 1 cycle between nibbles.
- sub=1, a=8'h05, b=8'h05 -> result=8'h00, zero=1, c_out=1, ovf=0; slice sees add_b nibbles 4'hA, 4'hF and first add_c_in=1.
- a=8'hFF, b=8'h01, c_in=0 -> result=8'h00, c_out=1, zero=1; second-nibble add_c_in=1.
- Slice never asserts ready -> err pulse after TIMEOUT wait cycles on nibble 0, add_en=0, no done, busy clears, next start accepted.
- rst_n asserted while in WAIT of nibble 1 -> all outputs at reset values immediately, no done/err; a subsequent request completes correctly.
- start held high continuously across two operations -> second operation begins only after return to IDLE; done pulses once per operation.

Source files
------------

// File: rtl/nibble_seq_pkg.sv
// Shared types and helpers for the nibble-serial add/sub sequencer.
// Holds the FSM state encoding, the slice width and the overflow rule.
package nibble_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StGap,
    StDone
  } state_e;

  // Signed overflow: operand signs agree (B already inverted for sub), result sign differs.
  function automatic logic calc_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/nibble_add_sequencer.sv
// Drives one shared 4-bit adder slice nibble by nibble (LSB first) over an en/ready
// handshake, rippling the carry, to perform a W-bit add or subtract.
module nibble_add_sequencer
  import nibble_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 2,
  parameter int unsigned TIMEOUT = 15,
  localparam int unsigned W = NIBBLE_W * NIBBLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic                c_in,
  input  logic [W-1:0]        a,
  input  logic [W-1:0]        b,
  output logic                add_en,
  output logic [NIBBLE_W-1:0] add_a,
  output logic [NIBBLE_W-1:0] add_b,
  output logic                add_c_in,
  input  logic [NIBBLE_W-1:0] add_sum,
  input  logic                add_c_out,
  input  logic                add_ready,
  output logic                busy,
  output logic [W-1:0]        result,
  output logic                c_out,
  output logic                ovf,
  output logic                zero,
  output logic                done,
  output logic                err
);

  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry_q;
  logic [IdxW-1:0] idx_q;
  logic [CntW-1:0] wait_cnt_q;

  logic [W-1:0]    b_eff;
  logic            carry_init;
  logic [IdxW-1:0] idx_nxt;
  logic            last_nibble;

  always_comb begin
    b_eff       = b ^ {W{sub}};
    carry_init  = sub | c_in;
    idx_nxt     = idx_q + 1'b1;
    last_nibble = (idx_q == IdxW'(NIBBLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      wait_cnt_q <= '0;
      add_en     <= 1'b0;
      add_a      <= '0;
      add_b      <= '0;
      add_c_in   <= 1'b0;
      busy       <= 1'b0;
      result     <= '0;
      c_out      <= 1'b0;
      ovf        <= 1'b0;
      zero       <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // busy stays high through a done/err cycle, then follows start here.
          busy <= start;
          if (start) begin
            a_q      <= a;
            b_q      <= b_eff;
            carry_q  <= carry_init;
            result   <= '0;
            idx_q    <= '0;
            add_en   <= 1'b1;
            add_a    <= a[NIBBLE_W-1:0];
            add_b    <= b_eff[NIBBLE_W-1:0];
            add_c_in <= carry_init;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          wait_cnt_q <= '0;
          state_q    <= StWait;
        end
        StWait: begin
          if (add_ready) begin
            result[idx_q*NIBBLE_W +: NIBBLE_W] <= add_sum;
            carry_q <= add_c_out;
            add_en  <= 1'b0;
            state_q <= StGap;
          end else if (wait_cnt_q == CntW'(TIMEOUT - 1)) begin
            add_en  <= 1'b0;
            err     <= 1'b1;
            state_q <= StIdle;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StGap: begin
          if (!last_nibble) begin
            idx_q    <= idx_nxt;
            add_en   <= 1'b1;
            add_a    <= a_q[idx_nxt*NIBBLE_W +: NIBBLE_W];
            add_b    <= b_q[idx_nxt*NIBBLE_W +: NIBBLE_W];
            add_c_in <= carry_q;
            state_q  <= StIssue;
          end else begin
            c_out   <= carry_q;
            ovf     <= calc_ovf(a_q[W-1], b_q[W-1], result[W-1]);
            zero    <= (result == '0);
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
